// File: rtl/maxnet_update_unit.sv
// maxnet_update_unit: Maxnet iteration controller and ReLU write-back stage feeding the weighted-sum units.
// Optional iteration cap enabled by defining MAXNET_ITER_LIMIT_EN.
module maxnet_update_unit #(
  parameter int XLEN     = 32,
  parameter int PU_LAT   = 2,
  parameter int MAX_ITER = 64,
  parameter int ITW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] init0,
  input  logic [XLEN-1:0] init1,
  input  logic [XLEN-1:0] init2,
  input  logic [XLEN-1:0] init3,
  input  logic [XLEN-1:0] res0,
  input  logic [XLEN-1:0] res1,
  input  logic [XLEN-1:0] res2,
  input  logic [XLEN-1:0] res3,
  output logic [XLEN-1:0] num0,
  output logic [XLEN-1:0] num1,
  output logic [XLEN-1:0] num2,
  output logic [XLEN-1:0] num3,
  output logic            busy,
  output logic            done,
  output logic            winner_valid,
  output logic [1:0]      winner_idx,
  output logic [ITW-1:0]  iter_cnt,
  output logic            timeout
);
  localparam int WCW = $clog2(PU_LAT + 1);
`ifdef MAXNET_ITER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CHECK, WAIT, UPDATE, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] num_q [4];
  logic [XLEN-1:0] num_n [4];
  logic [ITW-1:0]  iter_n;
  logic [WCW-1:0]  wcnt_q, wcnt_n;
  logic            wv_n, to_n, cap;
  logic [1:0]      widx_n, idx;
  logic [3:0]      nz;
  logic [2:0]      cnt;
  function automatic logic [XLEN-1:0] relu(input logic [XLEN-1:0] v);
    return (v[XLEN-1] || ~|v[XLEN-2:0]) ? '0 : v;
  endfunction
  // -0 has only the sign bit set, so it counts as zero
  always_comb begin
    nz = '0;
    for (int i = 0; i < 4; i++) nz[i] = |num_q[i][XLEN-2:0];
  end
  assign cnt = 3'(nz[0]) + 3'(nz[1]) + 3'(nz[2]) + 3'(nz[3]);
  assign idx = nz[3] ? 2'd3 : nz[2] ? 2'd2 : nz[1] ? 2'd1 : 2'd0;
  assign cap = LIMIT_EN && (iter_cnt == ITW'(MAX_ITER));
  always_comb begin
    state_n = state;
    num_n   = num_q;
    iter_n  = iter_cnt;
    wcnt_n  = wcnt_q;
    wv_n    = winner_valid;
    widx_n  = winner_idx;
    to_n    = timeout;
    case (state)
      IDLE, DONE: if (start) begin
        num_n   = '{init0, init1, init2, init3};
        iter_n  = '0;
        wv_n    = 1'b0;
        widx_n  = 2'd0;
        to_n    = 1'b0;
        state_n = CHECK;
      end
      CHECK: begin
        // winner and all-zero outrank the iteration cap
        if (cnt == 3'd1) begin
          wv_n    = 1'b1;
          widx_n  = idx;
          state_n = DONE;
        end else if (cnt == 3'd0) begin
          wv_n    = 1'b0;
          state_n = DONE;
        end else if (cap) begin
          to_n    = 1'b1;
          wv_n    = 1'b0;
          widx_n  = 2'd0;
          state_n = DONE;
        end else begin
          wcnt_n  = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        wcnt_n  = wcnt_q + 1'b1;
        state_n = (wcnt_q == WCW'(PU_LAT - 1)) ? UPDATE : WAIT;
      end
      UPDATE: begin
        num_n   = '{relu(res0), relu(res1), relu(res2), relu(res3)};
        iter_n  = &iter_cnt ? iter_cnt : iter_cnt + 1'b1;
        state_n = CHECK;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      num_q        <= '{default: '0};
      iter_cnt     <= '0;
      wcnt_q       <= '0;
      winner_valid <= 1'b0;
      winner_idx   <= 2'd0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      num_q        <= num_n;
      iter_cnt     <= iter_n;
      wcnt_q       <= wcnt_n;
      winner_valid <= wv_n;
      winner_idx   <= widx_n;
      timeout      <= to_n;
      busy         <= (state_n == CHECK) || (state_n == WAIT) || (state_n == UPDATE);
      done         <= (state_n == DONE);
    end
  end
  assign num0 = num_q[0];
  assign num1 = num_q[1];
  assign num2 = num_q[2];
  assign num3 = num_q[3];
endmodule

// File: tb/tb_maxnet_update_unit.sv
// tb_maxnet_update_unit: randomized bench with an iteration-level reference schedule for maxnet_update_unit.
module tb_maxnet_update_unit;
  localparam int PU_LAT = 2, MAX_ITER = 4, ITW = 8, MAXI = 40;
`ifdef MAXNET_ITER_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0;
  logic [3:0][31:0] init_d = '0, res_d = '0;
  logic [31:0] num0, num1, num2, num3;
  logic busy, done, winner_valid, timeout;
  logic [1:0] winner_idx;
  logic [ITW-1:0] iter_cnt;
  always #5 clk = ~clk;
  maxnet_update_unit #(.XLEN(32), .PU_LAT(PU_LAT), .MAX_ITER(MAX_ITER), .ITW(ITW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .init0(init_d[0]), .init1(init_d[1]), .init2(init_d[2]), .init3(init_d[3]),
    .res0(res_d[0]), .res1(res_d[1]), .res2(res_d[2]), .res3(res_d[3]),
    .num0(num0), .num1(num1), .num2(num2), .num3(num3),
    .busy(busy), .done(done), .winner_valid(winner_valid), .winner_idx(winner_idx),
    .iter_cnt(iter_cnt), .timeout(timeout)
  );
  typedef struct packed {
    logic upd, busy, done, wv, to;
    logic [1:0] widx;
    logic [7:0] iter;
    logic [3:0][31:0] num;
    logic [3:0][31:0] res;
  } exp_t;
  exp_t q[$];
  exp_t cur = '0;
  int checks = 0, errors = 0;
  logic [3:0][31:0] res_tab [64];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [3:0][31:0] v4(input logic [31:0] a, b, c, d);
    v4[0] = a; v4[1] = b; v4[2] = c; v4[3] = d;
  endfunction
  function automatic logic [31:0] relu(input logic [31:0] v);
    return (v[31] || v[30:0] == 0) ? 32'h0 : v;
  endfunction
  // Expected per-cycle outputs following a start: CHECK, PU_LAT waits, UPDATE per iteration, then DONE
  task automatic build(input logic [3:0][31:0] ini);
    logic [3:0][31:0] a = ini;
    int it = 0, cnt, idx;
    exp_t e;
    q.delete();
    for (int k = 0; k < MAXI; k++) begin
      cnt = 0; idx = 0;
      for (int i = 0; i < 4; i++) if (a[i][30:0] != 0) begin cnt++; idx = i; end
      e = '0; e.busy = 1; e.num = a; e.iter = 8'(it);
      q.push_back(e);
      if (cnt <= 1 || (LIM && it == MAX_ITER)) begin
        e.busy = 0; e.done = 1; e.wv = (cnt == 1);
        e.widx = (cnt == 1) ? 2'(idx) : 2'd0;
        e.to = (cnt > 1);
        q.push_back(e);
        return;
      end
      repeat (PU_LAT) q.push_back(e);
      e.upd = 1; e.res = res_tab[it];
      q.push_back(e);
      for (int i = 0; i < 4; i++) a[i] = relu(res_tab[it][i]);
      it = (it < 255) ? it + 1 : 255;
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (q.size() > 0) cur = q.pop_front();
    check("busy", 32'(busy), 32'(cur.busy));
    check("done", 32'(done), 32'(cur.done));
    check("winner_valid", 32'(winner_valid), 32'(cur.wv));
    check("winner_idx", 32'(winner_idx), 32'(cur.widx));
    check("iter_cnt", 32'(iter_cnt), 32'(cur.iter));
    check("timeout", 32'(timeout), 32'(cur.to));
    check("num0", num0, cur.num[0]);
    check("num1", num1, cur.num[1]);
    check("num2", num2, cur.num[2]);
    check("num3", num3, cur.num[3]);
    res_d = cur.upd ? cur.res : v4($urandom, $urandom, $urandom, $urandom);
  end
  task automatic go(input logic [3:0][31:0] ini);
    @(negedge clk); #1;
    init_d = ini; start = 1; build(ini);
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_done(input int max, output int n, output int nb);
    n = 1; nb = busy ? 1 : 0;
    while (!done && n < max) begin
      @(posedge clk); #1;
      n++; nb += busy ? 1 : 0;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    q.delete(); cur = '0;
  endtask
  function automatic logic [31:0] rnd_val();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 3))
      0: x = 32'h0;
      1: x = 32'h8000_0000;
      2: begin x[31] = 1'b0; if (x[30:0] == 0) x[0] = 1'b1; end
      default: x[31] = 1'b1;
    endcase
    return x;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, nb;
    for (int k = 0; k < 64; k++) res_tab[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_num0", num0, 0);
    check("rst_iter", 32'(iter_cnt), 0);
    rst = 0;
    go(v4(32'h3F800000, 0, 0, 0));
    wait_done(20, n, nb);
    check("imm_latency", n, 2);
    check("imm_wv", 32'(winner_valid), 1);
    check("imm_idx", 32'(winner_idx), 0);
    check("imm_iter", 32'(iter_cnt), 0);
    res_tab[0] = v4(32'h3F400000, 32'hBE800000, 0, 0);
    go(v4(32'h3F800000, 32'h3F000000, 0, 0));
    wait_done(20, n, nb);
    check("relu_latency", n, 6);
    check("relu_num0", num0, 32'h3F400000);
    check("relu_num1", num1, 0);
    check("relu_wv", 32'(winner_valid), 1);
    check("relu_iter", 32'(iter_cnt), 1);
    res_tab[0] = v4(32'h80000000, 32'hBF800000, 0, 0);
    go(v4(32'h3F800000, 32'h3F800000, 0, 0));
    wait_done(20, n, nb);
    check("zero_wv", 32'(winner_valid), 0);
    check("zero_iter", 32'(iter_cnt), 1);
    check("zero_num0", num0, 0);
    res_tab[0] = v4(32'h3F000000, 32'h3E800000, 32'h3F000000, 0);
    res_tab[1] = v4(0, 32'h3E000000, 32'h3F000000, 32'hBF000000);
    res_tab[2] = v4(32'h80000000, 0, 32'h3E800000, 0);
    go(v4(32'h3F800000, 32'h3F666666, 32'h3F4CCCCD, 32'h3F333333));
    wait_done(40, n, nb);
    check("multi_busy_cycles", nb, 3 * (PU_LAT + 2) + 1);
    check("multi_idx", 32'(winner_idx), 2);
    check("multi_iter", 32'(iter_cnt), 3);
    check("multi_num2", num2, 32'h3E800000);
    go(v4(32'h3F800000, 32'h3F666666, 32'h3F4CCCCD, 32'h3F333333));
    @(posedge clk); #2 rst = 1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_num0", num0, 0);
    check("arst_num1", num1, 0);
    @(posedge clk); #1 rst = 0;
    q.delete(); cur = '0;
    go(v4(32'h3F800000, 32'h3F666666, 32'h3F4CCCCD, 32'h3F333333));
    @(posedge clk);
    @(negedge clk); #1;
    init_d = v4(32'h3F800000, 0, 0, 0); start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(40, n, nb);
    check("ign_iter", 32'(iter_cnt), 3);
    check("ign_idx", 32'(winner_idx), 2);
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 64; k++)
        res_tab[k] = (k >= 6) ? '0 : v4(rnd_val(), rnd_val(), rnd_val(), rnd_val());
      go(v4(rnd_val(), rnd_val(), rnd_val(), rnd_val()));
      wait_done(100, n, nb);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    for (int k = 0; k < 64; k++) res_tab[k] = v4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    go(v4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000));
`ifdef MAXNET_ITER_LIMIT_EN
    wait_done(100, n, nb);
    check("cap_timeout", 32'(timeout), 1);
    check("cap_iter", 32'(iter_cnt), MAX_ITER);
    check("cap_wv", 32'(winner_valid), 0);
`else
    repeat (100) @(posedge clk);
    #1;
    check("nocap_busy", 32'(busy), 1);
    check("nocap_timeout", 32'(timeout), 0);
`endif
    do_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
